video_xbar_frame_sync: RTL and testbench
========================================

// Module: video_xbar_frame_sync
// PURPOSE
// - Parametrised N_SRC x N_DST crossbar for the video pipeline (h_count, v_count, active_draw, pixel).
// - Routes the base generator and effect stages to effect inputs and to the HDMI output.
// - One select code is an alias that resolves to a separately supplied select (the delay slot).
// - Each destination changes source only on a frame boundary of the new source, so no torn frames
//   reach the display. A timeout forces the change if that frame boundary never arrives.
// PARAMETERS
// N_SRC      6     number of source streams; index 0 = base generator
// N_DST      5     number of destination streams
// SEL_W      3     select width; requires 2**SEL_W > N_SRC
// ALIAS_SEL  1     select code that resolves to alias_sel
// TIMEOUT    2**21 cycles to wait in PENDING before a forced switch; >= 1 full frame
// PORTS
// clk            in   1             pixel clock
// rst_n          in   1             asynchronous active-low reset
// alias_sel      in   SEL_W         source used wherever a dst_sel lane equals ALIAS_SEL
// dst_sel        in   N_DST*SEL_W   requested source per destination; lane d = [d*SEL_W +: SEL_W]
// h_count_in     in   N_SRC*11      per-source h_count
// v_count_in     in   N_SRC*10      per-source v_count
// active_in      in   N_SRC         per-source active_draw
// pixel_in       in   N_SRC*24      per-source RGB pixel
// h_count_out    out  N_DST*11      per-destination h_count
// v_count_out    out  N_DST*10      per-destination v_count
// active_out     out  N_DST         per-destination active_draw
// pixel_out      out  N_DST*24      per-destination pixel
// switching      out  N_DST         1 while destination d is PENDING
// sel_error      out  N_DST         1 while destination d's resolved select is invalid
// forced_switch  out  N_DST         1-cycle pulse when a switch is forced by timeout
// BEHAVIOUR
// - Reset (rst_n low, async): all outputs 0; committed select C[d] = 0; resolved select R[d] = 0;
//   FSM = IDLE; timeout counters = 0. Reset mid-PENDING abandons the switch and returns to source 0.
// - Stage 1 (registered), every cycle:
//   - every source input is captured as S1[s].
//   - R[d] = (dst_sel[d] == ALIAS_SEL) ? alias_sel : dst_sel[d].
//   - R[d] is invalid if it is >= N_SRC or still equals ALIAS_SEL.
// - Data latency is 2 cycles: input -> S1 -> output register. Data has no backpressure or stall.
// - Output register captures S1[Cn[d]], where Cn is the next-cycle committed select.
//   The beat that triggers a commit is therefore the first beat output from the new source.
// - Per-destination FSM, transitions evaluated on the registered R:
//   - IDLE -> PENDING: R valid and R != C. Set T = R, cnt = 0, switching = 1.
//   - PENDING -> IDLE (commit): S1[T] h == 0 and v == 0. Set C = T.
//   - PENDING -> IDLE (forced): cnt reaches TIMEOUT-1. Set C = T and pulse forced_switch for 1 cycle.
//   - PENDING, R valid and R != T and R != C: retarget T = R, cnt = 0.
//   - PENDING, R == C: abort to IDLE; C is unchanged.
//   - PENDING, R invalid: stay PENDING on the current T; cnt keeps running.
// - Invalid R in any state: sel_error = 1; C is kept, and the output keeps streaming the committed source.
// - Frame start coinciding with a retarget: the frame start is tested against the old T only.
// - cnt saturates; it is cleared on every entry to PENDING and on every retarget.
// - Destinations are independent. Any number may select the same source.
//   A destination may select its own effect's output; no loop detection is done.
// - All status outputs are registered and valid in the same cycle as the FSM state they report.
// TESTING
// 1. Reset, then stream src0 ramp pixels with dst_sel all 0.
//    -> every out equals the in delayed 2 cycles; switching = 0.
// 2. dst0: sel 0 -> 3 mid-frame (src3 at h=400, v=200).
//    -> switching = 1; out stays src0 until src3 h=0,v=0. First src3 beat out is exactly (0,0).
// 3. alias_sel = 4 and dst2 sel = ALIAS_SEL (1).
//    -> dst2 switches to src4 at its frame start. Then alias_sel 4 -> 5: dst2 goes PENDING and switches at src5's frame start.
// 4. TIMEOUT = 64, src3 h/v held at 5. dst1 sel -> 3.
//    -> forced_switch pulses at cnt 63; out is src3 on the next beat.
// 5. dst0 sel = 7 (N_SRC = 6).
//    -> sel_error = 1; output stays on the committed source; no PENDING.
//    Then dst0 sel 0 -> 2 -> 0 while PENDING -> abort; switching drops; C = 0.
// 6. rst_n low while dst3 is PENDING.
//    -> all outputs 0 asynchronously; after release, C[3] = 0 and state is IDLE.

Source files
------------

// File: rtl/video_xbar_frame_sync.sv
`default_nettype none
// ============================================================================
// Module  : video_xbar_frame_sync
// Purpose : N_SRC x N_DST video crossbar; each destination changes source only
//           on the new source's frame start, or when the timeout expires.
// Rev     : 1.0  initial release
// ============================================================================
module video_xbar_frame_sync #(
  parameter int N_SRC     = 6,
  parameter int N_DST     = 5,
  parameter int SEL_W     = 3,
  parameter int ALIAS_SEL = 1,
  parameter int TIMEOUT   = 2**21
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       alias_sel,
  input  logic [N_DST*SEL_W-1:0] dst_sel,
  input  logic [N_SRC*11-1:0]    h_count_in,
  input  logic [N_SRC*10-1:0]    v_count_in,
  input  logic [N_SRC-1:0]       active_in,
  input  logic [N_SRC*24-1:0]    pixel_in,
  output logic [N_DST*11-1:0]    h_count_out,
  output logic [N_DST*10-1:0]    v_count_out,
  output logic [N_DST-1:0]       active_out,
  output logic [N_DST*24-1:0]    pixel_out,
  output logic [N_DST-1:0]       switching,
  output logic [N_DST-1:0]       sel_error,
  output logic [N_DST-1:0]       forced_switch
);

  localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SEL_W-1:0]   c_ALIAS    = SEL_W'(ALIAS_SEL);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [N_SRC*11-1:0] r_s1_h;
  logic [N_SRC*10-1:0] r_s1_v;
  logic [N_SRC-1:0]    r_s1_a;
  logic [N_SRC*24-1:0] r_s1_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_h <= '0;
      r_s1_v <= '0;
      r_s1_a <= '0;
      r_s1_p <= '0;
    end else begin
      r_s1_h <= h_count_in;
      r_s1_v <= v_count_in;
      r_s1_a <= active_in;
      r_s1_p <= pixel_in;
    end
  end

  for (genvar d = 0; d < N_DST; d++) begin : g_dst
    logic [SEL_W-1:0]   w_req;
    logic [SEL_W-1:0]   w_res;
    logic               w_res_bad;
    logic [SEL_W-1:0]   r_rsel;
    logic               r_rbad;
    state_t             r_state;
    logic [SEL_W-1:0]   r_commit;
    logic [SEL_W-1:0]   r_target;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_switching;
    logic               r_forced;
    logic               w_rvalid;
    logic               w_t_fs;
    logic               w_abort;
    logic               w_take;
    logic               w_force;
    logic [SEL_W-1:0]   w_cn;
    logic [10:0]        r_h;
    logic [9:0]         r_v;
    logic               r_a;
    logic [23:0]        r_p;

    // The alias code itself is never a real source, even if alias_sel points back at it.
    assign w_req     = dst_sel[d*SEL_W +: SEL_W];
    assign w_res     = (w_req == c_ALIAS) ? alias_sel : w_req;
    assign w_res_bad = (int'(w_res) >= N_SRC) || (w_res == c_ALIAS);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rsel <= '0;
        r_rbad <= 1'b0;
      end else begin
        r_rsel <= w_res;
        r_rbad <= w_res_bad;
      end
    end

    assign w_rvalid = !r_rbad;

    always_comb begin
      w_t_fs = 1'b0;
      for (int s = 0; s < N_SRC; s++) begin
        if (r_target == SEL_W'(s)) begin
          w_t_fs = (r_s1_h[s*11 +: 11] == 11'd0) && (r_s1_v[s*10 +: 10] == 10'd0);
        end
      end
    end

    // Abort wins over a coincident frame start; a frame start wins over the timeout.
    assign w_abort = (r_state == ST_PENDING) && w_rvalid && (r_rsel == r_commit);
    assign w_take  = (r_state == ST_PENDING) && !w_abort && w_t_fs;
    assign w_force = (r_state == ST_PENDING) && !w_abort && !w_t_fs && (r_cnt == c_CNT_LAST);
    assign w_cn    = (w_take || w_force) ? r_target : r_commit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= ST_IDLE;
        r_commit    <= '0;
        r_target    <= '0;
        r_cnt       <= '0;
        r_switching <= 1'b0;
        r_forced    <= 1'b0;
      end else begin
        r_forced <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_rvalid && (r_rsel != r_commit)) begin
              r_state     <= ST_PENDING;
              r_target    <= r_rsel;
              r_cnt       <= '0;
              r_switching <= 1'b1;
            end
          end
          ST_PENDING: begin
            if (w_abort) begin
              r_state     <= ST_IDLE;
              r_switching <= 1'b0;
            end else if (w_take || w_force) begin
              r_state     <= ST_IDLE;
              r_commit    <= r_target;
              r_switching <= 1'b0;
              r_forced    <= w_force;
            end else if (w_rvalid && (r_rsel != r_target)) begin
              r_target <= r_rsel;
              r_cnt    <= '0;
            end else if (r_cnt != {c_CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_switching <= 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_h <= '0;
        r_v <= '0;
        r_a <= 1'b0;
        r_p <= '0;
      end else begin
        for (int s = 0; s < N_SRC; s++) begin
          if (w_cn == SEL_W'(s)) begin
            r_h <= r_s1_h[s*11 +: 11];
            r_v <= r_s1_v[s*10 +: 10];
            r_a <= r_s1_a[s];
            r_p <= r_s1_p[s*24 +: 24];
          end
        end
      end
    end

    assign h_count_out[d*11 +: 11] = r_h;
    assign v_count_out[d*10 +: 10] = r_v;
    assign active_out[d]           = r_a;
    assign pixel_out[d*24 +: 24]   = r_p;
    assign switching[d]            = r_switching;
    assign sel_error[d]            = r_rbad;
    assign forced_switch[d]        = r_forced;
  end

endmodule
`default_nettype wire

// File: tb/tb_video_xbar_frame_sync.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_xbar_frame_sync
// Purpose : Self-checking bench for video_xbar_frame_sync (directed + random).
// Rev     : 1.0  initial release
// ============================================================================
module tb_video_xbar_frame_sync;
  localparam int N_SRC     = 6;
  localparam int N_DST     = 5;
  localparam int SEL_W     = 3;
  localparam int ALIAS_SEL = 1;
  localparam int TIMEOUT   = 64;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b1;
  logic [SEL_W-1:0]       alias_sel;
  logic [N_DST*SEL_W-1:0] dst_sel;
  logic [N_SRC*11-1:0]    h_in;
  logic [N_SRC*10-1:0]    v_in;
  logic [N_SRC-1:0]       a_in;
  logic [N_SRC*24-1:0]    p_in;
  logic [N_DST*11-1:0]    h_count_out;
  logic [N_DST*10-1:0]    v_count_out;
  logic [N_DST-1:0]       active_out;
  logic [N_DST*24-1:0]    pixel_out;
  logic [N_DST-1:0]       switching;
  logic [N_DST-1:0]       sel_error;
  logic [N_DST-1:0]       forced_switch;

  always #5 clk = ~clk;

  video_xbar_frame_sync #(
    .N_SRC(N_SRC), .N_DST(N_DST), .SEL_W(SEL_W), .ALIAS_SEL(ALIAS_SEL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .alias_sel(alias_sel), .dst_sel(dst_sel),
    .h_count_in(h_in), .v_count_in(v_in), .active_in(a_in), .pixel_in(p_in),
    .h_count_out(h_count_out), .v_count_out(v_count_out), .active_out(active_out),
    .pixel_out(pixel_out), .switching(switching), .sel_error(sel_error),
    .forced_switch(forced_switch)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-source raster generators; pixel = {source id, cycle stamp}.
  int hc[N_SRC], vc[N_SRC], hmax[N_SRC], vmax[N_SRC];
  bit hold[N_SRC];
  int cyc;

  task automatic set_src(input int s, input int h, input int v, input int hm, input int vm, input bit hd);
    hc[s] = h; vc[s] = v; hmax[s] = hm; vmax[s] = vm; hold[s] = hd;
  endtask

  task automatic drive_inputs();
    for (int s = 0; s < N_SRC; s++) begin
      h_in[s*11 +: 11] = 11'(hc[s]);
      v_in[s*10 +: 10] = 10'(vc[s]);
      a_in[s]          = ((hc[s] + vc[s]) % 3) != 0;
      p_in[s*24 +: 24] = {4'(s), 20'(cyc)};
    end
  endtask

  task automatic advance();
    cyc++;
    for (int s = 0; s < N_SRC; s++) begin
      if (!hold[s]) begin
        hc[s]++;
        if (hc[s] >= hmax[s]) begin
          hc[s] = 0;
          vc[s] = (vc[s] + 1 >= vmax[s]) ? 0 : vc[s] + 1;
        end
      end
    end
  endtask

  // Reference model: remembers the snapshot of inputs seen one edge ago and
  // applies the switching rules to it.
  typedef struct packed {
    logic [N_SRC*11-1:0]    h;
    logic [N_SRC*10-1:0]    v;
    logic [N_SRC-1:0]       a;
    logic [N_SRC*24-1:0]    p;
    logic [N_DST*SEL_W-1:0] sel;
    logic [SEL_W-1:0]       al;
  } snap_t;

  snap_t m_prev;
  bit    m_pend[N_DST];
  int    m_tgt[N_DST], m_com[N_DST], m_wait[N_DST];
  logic [N_DST*11-1:0] e_h;
  logic [N_DST*10-1:0] e_v;
  logic [N_DST-1:0]    e_a, e_sw, e_err, e_fs;
  logic [N_DST*24-1:0] e_p;

  function automatic int resolve(input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] al);
    int r;
    r = s;
    if (r == ALIAS_SEL) r = al;
    return r;
  endfunction

  function automatic bit sel_ok(input int r);
    return (r < N_SRC) && (r != ALIAS_SEL);
  endfunction

  task automatic model_reset();
    m_prev = '0;
    for (int d = 0; d < N_DST; d++) begin
      m_pend[d] = 0; m_tgt[d] = 0; m_com[d] = 0; m_wait[d] = 0;
    end
    e_h = '0; e_v = '0; e_a = '0; e_p = '0; e_sw = '0; e_err = '0; e_fs = '0;
  endtask

  task automatic model_step();
    snap_t cur;
    cur.h = h_in; cur.v = v_in; cur.a = a_in; cur.p = p_in;
    cur.sel = dst_sel; cur.al = alias_sel;
    for (int d = 0; d < N_DST; d++) begin
      int r;
      bit ok, fs;
      r  = resolve(m_prev.sel[d*SEL_W +: SEL_W], m_prev.al);
      ok = sel_ok(r);
      fs = (m_prev.h[m_tgt[d]*11 +: 11] == 0) && (m_prev.v[m_tgt[d]*10 +: 10] == 0);
      e_fs[d] = 1'b0;
      if (!m_pend[d]) begin
        if (ok && r != m_com[d]) begin
          m_pend[d] = 1; m_tgt[d] = r; m_wait[d] = 0;
        end
      end else if (ok && r == m_com[d]) begin
        m_pend[d] = 0;
      end else if (fs) begin
        m_com[d] = m_tgt[d]; m_pend[d] = 0;
      end else if (m_wait[d] >= TIMEOUT - 1) begin
        m_com[d] = m_tgt[d]; m_pend[d] = 0; e_fs[d] = 1'b1;
      end else if (ok && r != m_tgt[d]) begin
        m_tgt[d] = r; m_wait[d] = 0;
      end else begin
        m_wait[d]++;
      end
      e_h[d*11 +: 11] = m_prev.h[m_com[d]*11 +: 11];
      e_v[d*10 +: 10] = m_prev.v[m_com[d]*10 +: 10];
      e_a[d]          = m_prev.a[m_com[d]];
      e_p[d*24 +: 24] = m_prev.p[m_com[d]*24 +: 24];
      e_sw[d]         = m_pend[d];
      e_err[d]        = !sel_ok(resolve(cur.sel[d*SEL_W +: SEL_W], cur.al));
    end
    m_prev = cur;
  endtask

  task automatic model_check();
    chk("model", {h_count_out, v_count_out, active_out, pixel_out, switching, sel_error, forced_switch},
        {e_h, e_v, e_a, e_p, e_sw, e_err, e_fs});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    model_check();
    advance();
    drive_inputs();
  endtask

  function automatic logic [3:0] src_of(input int d);
    return pixel_out[d*24+20 +: 4];
  endfunction

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] al;
    logic             exp_err;
  } vec_t;
  vec_t tbl[12];

  int n, first_k, rd, rs;
  bit sw_before;

  initial begin
    tbl[0]  = '{3'd0, 3'd0, 1'b0};  tbl[1]  = '{3'd2, 3'd0, 1'b0};
    tbl[2]  = '{3'd5, 3'd0, 1'b0};  tbl[3]  = '{3'd6, 3'd0, 1'b1};
    tbl[4]  = '{3'd7, 3'd0, 1'b1};  tbl[5]  = '{3'd1, 3'd4, 1'b0};
    tbl[6]  = '{3'd1, 3'd1, 1'b1};  tbl[7]  = '{3'd1, 3'd6, 1'b1};
    tbl[8]  = '{3'd1, 3'd7, 1'b1};  tbl[9]  = '{3'd1, 3'd0, 1'b0};
    tbl[10] = '{3'd3, 3'd7, 1'b0};  tbl[11] = '{3'd1, 3'd5, 1'b0};

    for (int s = 0; s < N_SRC; s++) set_src(s, 10 + s, 3, 1000, 500, 0);
    set_src(2, 50, 3, 900, 400, 0);
    cyc = 0; dst_sel = '0; alias_sel = '0;
    drive_inputs();
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", {h_count_out, v_count_out, active_out, pixel_out, switching, sel_error, forced_switch}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Stream src0 to every destination with 2-cycle latency
    repeat (4) tick();
    for (int d = 0; d < N_DST; d++)
      chk($sformatf("t1_pixel_d%0d", d), pixel_out[d*24 +: 24], {4'd0, 20'(cyc - 2)});
    chk("t1_switching", switching, '0);

    // dst0 -> src3 mid-frame, switch lands exactly on src3's (0,0)
    set_src(3, 400, 200, 404, 201, 0);
    drive_inputs();
    dst_sel[0 +: SEL_W] = 3'd3;
    repeat (2) tick();
    chk("t2_switching", switching[0], 1'b1);
    chk("t2_still_src0", src_of(0), 4'd0);
    n = 0;
    while (src_of(0) != 4'd3 && n < 40) begin tick(); n++; end
    chk("t2_switch_bound", n < 40, 1'b1);
    chk("t2_first_hv", {h_count_out[0 +: 11], v_count_out[0 +: 10]}, '0);
    chk("t2_switch_done", switching[0], 1'b0);

    // dst2 via alias: src4, then alias retarget to src5
    set_src(4, 3, 0, 8, 2, 0);
    set_src(5, 2, 1, 7, 3, 0);
    drive_inputs();
    alias_sel = 3'd4;
    dst_sel[2*SEL_W +: SEL_W] = 3'd1;
    n = 0;
    while (src_of(2) != 4'd4 && n < 60) begin tick(); n++; end
    chk("t3_alias4_bound", n < 60, 1'b1);
    chk("t3_alias4_hv", {h_count_out[22 +: 11], v_count_out[20 +: 10]}, '0);
    alias_sel = 3'd5;
    repeat (2) tick();
    chk("t3_alias5_pending", switching[2], 1'b1);
    n = 0;
    while (src_of(2) != 4'd5 && n < 60) begin tick(); n++; end
    chk("t3_alias5_bound", n < 60, 1'b1);
    chk("t3_alias5_hv", {h_count_out[22 +: 11], v_count_out[20 +: 10]}, '0);

    // dst1 -> src3 whose frame start never arrives: forced after TIMEOUT
    set_src(3, 5, 5, 404, 201, 1);
    drive_inputs();
    dst_sel[1*SEL_W +: SEL_W] = 3'd3;
    first_k = 0; sw_before = 0;
    for (int k = 1; k <= 200 && first_k == 0; k++) begin
      tick();
      if (k == 65) sw_before = switching[1];
      if (forced_switch[1]) first_k = k;
    end
    chk("t4_forced_cycle", first_k, 66);
    chk("t4_pending_before", sw_before, 1'b1);
    chk("t4_src3_out", src_of(1), 4'd3);
    tick();
    chk("t4_pulse_one_cycle", forced_switch[1], 1'b0);

    // Invalid select keeps the committed source; then 0 -> 2 -> 0 aborts
    dst_sel[0 +: SEL_W] = 3'd7;
    repeat (3) tick();
    chk("t5_sel_error", sel_error[0], 1'b1);
    chk("t5_no_pending", switching[0], 1'b0);
    chk("t5_keeps_src3", src_of(0), 4'd3);
    dst_sel[0 +: SEL_W] = 3'd0;
    n = 0;
    while (src_of(0) != 4'd0 && n < 150) begin tick(); n++; end
    chk("t5_back_to_src0", n < 150, 1'b1);
    dst_sel[0 +: SEL_W] = 3'd2;
    repeat (2) tick();
    chk("t5_pending_src2", switching[0], 1'b1);
    dst_sel[0 +: SEL_W] = 3'd0;
    repeat (2) tick();
    chk("t5_abort", switching[0], 1'b0);
    chk("t5_abort_src0", src_of(0), 4'd0);
    chk("t5_abort_no_force", forced_switch[0], 1'b0);

    // Reset while dst3 is pending
    dst_sel[3*SEL_W +: SEL_W] = 3'd2;
    repeat (3) tick();
    chk("t6_pending", switching[3], 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("t6_async_reset", {h_count_out, v_count_out, active_out, pixel_out, switching, sel_error, forced_switch}, '0);
    dst_sel = '0; alias_sel = '0;
    model_reset();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_idle_after", switching[3], 1'b0);
    chk("t6_src0_after", src_of(3), 4'd0);

    // Select resolution table
    for (int i = 0; i < 12; i++) begin
      dst_sel[4*SEL_W +: SEL_W] = tbl[i].sel;
      alias_sel = tbl[i].al;
      tick();
      chk($sformatf("tbl%0d_sel_error", i), sel_error[4], tbl[i].exp_err);
    end

    // Randomized traffic against the model
    for (int s = 0; s < N_SRC; s++)
      set_src(s, 0, 0, $urandom_range(2, 12), $urandom_range(1, 3), 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rd = $urandom_range(0, N_DST - 1);
        dst_sel[rd*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 31) == 0) alias_sel = SEL_W'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        rs = $urandom_range(0, N_SRC - 1);
        hold[rs] = !hold[rs];
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
